// File: rtl/cla_pkg.sv
// Shared widths and the stage-1 register layout for the pipelined CLA subtractor.
package cla_pkg;
   localparam int CLA_W   = 8;
   localparam int CLA_GRP = 4;

   // Lower-nibble result plus the upper-nibble operands still waiting for stage 2
   typedef struct packed {
      logic [CLA_GRP-1:0] lo_diff;
      logic               c4;
      logic [CLA_GRP-1:0] a_hi;
      logic [CLA_GRP-1:0] nb_hi;
   } s1_t;
endpackage

// File: rtl/borrow_lookahead_4.sv
// 4-bit carry-lookahead group: every carry is a flat sum of products, no ripple.
module borrow_lookahead_4
   import cla_pkg::*;
(
   input  logic [CLA_GRP-1:0] p,
   input  logic [CLA_GRP-1:0] g,
   input  logic               cin,
   output logic [CLA_GRP:1]   c
);

   always_comb begin
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
   end

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined 8-bit subtractor (a - b - bin) built from lookahead groups.
// Define CLA_SUB_OVF_EN to add the signed-overflow output ovf.
module cla_sub_pipe
   import cla_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [CLA_W-1:0] a,
   input  logic [CLA_W-1:0] b,
   input  logic             bin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [CLA_W-1:0] diff,
   output logic             bout,
`ifdef CLA_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             out_valid,
   input  logic             out_ready
);

   logic [CLA_W-1:0]   nb;
   logic [CLA_GRP-1:0] g_lo, p_lo, g_hi, p_hi, hi_diff;
   logic [CLA_GRP:1]   c_lo, c_hi;
   logic               c0;
   s1_t                s1_d, s1_q;
   logic               s1_valid, s2_valid;
   logic               s1_adv, s2_adv;

   assign s2_adv    = !s2_valid | out_ready;
   assign s1_adv    = !s1_valid | s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   // Subtraction as a + ~b + ~bin; the final carry is the inverted borrow
   assign nb   = ~b;
   assign c0   = ~bin;
   assign g_lo = a[CLA_GRP-1:0] & nb[CLA_GRP-1:0];
   assign p_lo = a[CLA_GRP-1:0] ^ nb[CLA_GRP-1:0];

   borrow_lookahead_4 u_lo (
      .p   (p_lo),
      .g   (g_lo),
      .cin (c0),
      .c   (c_lo)
   );

   always_comb begin
      s1_d         = '0;
      s1_d.lo_diff = p_lo ^ {c_lo[3:1], c0};
      s1_d.c4      = c_lo[4];
      s1_d.a_hi    = a[CLA_W-1:CLA_GRP];
      s1_d.nb_hi   = nb[CLA_W-1:CLA_GRP];
   end

   assign g_hi = s1_q.a_hi & s1_q.nb_hi;
   assign p_hi = s1_q.a_hi ^ s1_q.nb_hi;

   borrow_lookahead_4 u_hi (
      .p   (p_hi),
      .g   (g_hi),
      .cin (s1_q.c4),
      .c   (c_hi)
   );

   assign hi_diff = p_hi ^ {c_hi[3:1], s1_q.c4};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid)
            s1_q <= s1_d;
      end
   end

   // Result registers only change when stage 2 advances, so a stalled result holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         diff     <= '0;
         bout     <= 1'b0;
`ifdef CLA_SUB_OVF_EN
         ovf      <= 1'b0;
`endif
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            diff <= {hi_diff, s1_q.lo_diff};
            bout <= ~c_hi[4];
`ifdef CLA_SUB_OVF_EN
            ovf  <= c_hi[3] ^ c_hi[4];
`endif
         end
      end
   end

endmodule

// File: doc/cla_sub_pipe.md
CLA_SUB_PIPE -- requirements
Module: cla_sub_pipe

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port a, input, 8, minuend.
REQ-004 SHALL have port b, input, 8, subtrahend.
REQ-005 SHALL have port bin, input, 1, borrow-in.
REQ-006 SHALL have port in_valid, input, 1, operands present.
REQ-007 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have port diff, output, 8, a - b - bin modulo 256.
REQ-009 SHALL have port bout, output, 1, borrow-out; 1 when a < b + bin, unsigned.
REQ-010 SHALL have port ovf, output, 1, signed two's-complement overflow; present only with CLA_SUB_OVF_EN.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.

Function
REQ-013 SHALL compute the result as a + ~b + ~bin using carry lookahead, with per-bit g = a & ~b, p = a ^ ~b, c0 = ~bin; bout = ~c8.
REQ-014 SHALL use a 2-stage pipeline; S1 holds diff[3:0], group carry c4 and the registered a[7:4] and ~b[7:4]; S2 holds the full diff and bout.
REQ-015 SHALL compute the S2 upper nibble from the registered S1 operands and c4 with a 4-bit lookahead group; no ripple between bits.
REQ-016 SHALL transfer on a handshake only when valid and ready are both 1 in the same cycle.
REQ-017 SHALL have a latency of 2 cycles from the input handshake to out_valid=1 when out_ready is held at 1.
REQ-018 SHALL sustain a throughput of 1 result per cycle when out_ready=1.
REQ-019 SHALL set S2 advance = !s2_valid | out_ready.
REQ-020 SHALL set S1 advance = !s1_valid | S2 advance.
REQ-021 SHALL drive in_ready = S1 advance combinationally, with no combinational path from in_valid.
REQ-022 SHALL hold diff, bout, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL on a full stall (both stages valid, out_ready=0) hold in_ready=0 and drop no data.
REQ-024 SHALL when out_ready rises on a full pipe move S1 to S2 and accept a new input in the same cycle.
REQ-025 SHALL on out_valid=1 and out_ready=1 with S1 empty clear out_valid the next cycle unless S1 was loaded.
REQ-026 SHALL wrap diff modulo 256; 0x00 - 0xFF - 1 yields diff 0x00, bout 1.

Reset
REQ-027 SHALL on rst=1 immediately clear s1_valid, s2_valid and out_valid; diff=0x00, bout=0, ovf=0, in_ready=1 after reset.
REQ-028 SHALL discard all in-flight operations if rst asserts mid-operation; none appear after release.
REQ-029 SHALL accept input in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, when macro CLA_SUB_OVF_EN is defined, compute ovf = c7 ^ c8 in S2 and register it with diff.
REQ-031 SHALL, when CLA_SUB_OVF_EN is undefined, omit the ovf port and its logic; all other behaviour is identical.

Structure
REQ-032 SHALL place in package cla_pkg: CLA_W=8, CLA_GRP=4 and the struct typedef s1_t {lo_diff, c4, a_hi, nb_hi}.
REQ-033 SHALL instantiate sub-module borrow_lookahead_4 (inputs p[3:0], g[3:0], cin; outputs c[4:1]) twice, once for the lower nibble and once for the upper nibble.

Verification
REQ-034 SHALL verify: a=0x50, b=0x20, bin=0, out_ready=1 -> diff=0x30, bout=0, out_valid 2 cycles after the handshake.
REQ-035 SHALL verify: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1.
REQ-036 SHALL verify with CLA_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x05, b=0x03 -> diff=0x02, ovf=0.
REQ-037 SHALL verify: 3 back-to-back inputs with out_ready=0 -> 2 accepted, in_ready=0, outputs stable; then out_ready=1 -> results in order, third input accepted the same cycle.
REQ-038 SHALL verify: rst pulsed with both stages full -> out_valid=0 immediately; no stale result after release.
REQ-039 SHALL verify: 10k random a, b, bin with random out_ready -> every result equals the reference model, in order, with no loss or duplication.
